fifo_mem: RTL and testbench
===========================

Name: fifo_mem

Overview:
- Single-clock synchronous FIFO buffer with show-ahead (first-word-fall-through) read data.
- Status outputs: full, empty, programmable threshold, overflow and underflow.
- Sits between a producer issuing single-cycle write strobes and a consumer issuing single-cycle read strobes. It decouples bursts of up to OSTD_NUM outstanding words.

Parameters:
- DATA_WIDTH, 16: width of each stored word and of data_in/data_out.
- OSTD_NUM, 16: FIFO depth (max outstanding words). Must be a power of two, at least 2.
- THRESHOLD_VALUE, OSTD_NUM/2: occupancy at or above which threshold_ind asserts. Legal range 1..OSTD_NUM.

Ports:
- clk_in, input, 1: clock. All state updates occur on its rising edge.
- areset_b, input, 1: synchronous, active-high reset. The name is kept per codebase; 1 = reset.
- trans_write, input, 1: write request for the current cycle.
- trans_read, input, 1: read (pop) request for the current cycle.
- data_in, input, DATA_WIDTH: write data, sampled on a rising edge with trans_write=1.
- data_out, output, DATA_WIDTH: head-of-FIFO word, valid whenever empty_ind=0.
- full_ind, output, 1: occupancy == OSTD_NUM.
- empty_ind, output, 1: occupancy == 0.
- overflow_ind, output, 1: write was attempted while full.
- underflow_ind, output, 1: read was attempted while empty.
- threshold_ind, output, 1: occupancy >= THRESHOLD_VALUE.

Behaviour:
- Storage and pointers:
  - Storage is an OSTD_NUM x DATA_WIDTH register array. The array is not reset.
  - wr_ptr and rd_ptr are each log2(OSTD_NUM)+1 bits. The low bits index the array; the MSB is the wrap bit.
  - Occupancy = wr_ptr - rd_ptr, modulo 2^(log2(OSTD_NUM)+1), range 0..OSTD_NUM.
  - Pointers wrap naturally; there is no special case at index OSTD_NUM-1.
- Reset: while areset_b=1 at a rising edge:
  - wr_ptr=0 and rd_ptr=0.
  - overflow_ind=0 and underflow_ind=0.
  - Consequently empty_ind=1, full_ind=0, threshold_ind=0, data_out=0.
  - Reset mid-operation discards all content; the next cycle behaves as a fresh FIFO.
- Write:
  - On a rising edge with trans_write=1 and either not full, or full with an accepted read in the same cycle: mem[wr_ptr] <= data_in and wr_ptr increments.
  - Otherwise the write is dropped and nothing changes.
- Read:
  - data_out = mem[rd_ptr[low bits]] combinationally when not empty, and 0 when empty.
  - On a rising edge with trans_read=1 and not empty: rd_ptr increments. The word presented on data_out before that edge is the one consumed.
  - Read latency is 0: a word written at edge N appears on data_out after edge N.
- Simultaneous read and write:
  - Not full and not empty: both occur; occupancy is unchanged.
  - Full: the read pops and the write is accepted; occupancy stays at OSTD_NUM and there is no overflow.
  - Empty: the write is accepted and the read is ignored; underflow_ind pulses and occupancy becomes 1.
- Status flags:
  - full_ind, empty_ind and threshold_ind are combinational from occupancy. They update in the cycle after the edge that changes occupancy.
- Error flags:
  - overflow_ind is registered. It is 1 for exactly the cycle following an edge where trans_write=1, the FIFO was full and no read was accepted. Otherwise 0.
  - underflow_ind is registered. It is 1 for exactly the cycle following an edge where trans_read=1 and the FIFO was empty. Otherwise 0.
  - Both flags are non-sticky; they re-pulse on each offending edge.
- Strobes held high across multiple edges act once per edge, i.e. multiple transfers.
- No X on any output after the first reset edge.

Test Plan:
- Basic write/read: after reset, write 15 words 0x0001..0x000F (one per strobe), then read 15.
  - data_out equals 1,2,...,15 in order at each read edge.
  - empty_ind=1 at the end; no overflow or underflow.
- Fill to full: 16 writes of 0x00A0..0x00AF.
  - full_ind=1 and threshold_ind=1.
  - A 17th write of 0xFFFF pulses overflow_ind for one cycle; the FIFO content is unchanged.
  - Draining yields 0xA0..0xAF.
- Threshold: write 7 words, then threshold_ind=0. 8th write makes threshold_ind=1. One read makes it 0 again.
- Underflow: read while empty.
  - underflow_ind pulses for 1 cycle, pointers stay at 0, data_out=0.
  - Simultaneous read and write of 0x1234 when empty leaves occupancy 1, data_out=0x1234, and an underflow pulse.
- Full with simultaneous read and write: with 16 stored words, read and write 0x5555 together.
  - full_ind stays 1, no overflow.
  - The popped word is the oldest; 0x5555 emerges last.
- Wrap and reset mid-operation:
  - Run 40 interleaved writes and reads with incrementing data; order is preserved across pointer wrap.
  - Assert areset_b=1 with 5 words stored: empty_ind=1, data_out=0 next cycle, and subsequent traffic starts from index 0.

Source files
------------

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Single-clock synchronous FIFO with show-ahead (first-word-fall-through) read
// data. The head word is presented combinationally on data_out whenever the
// FIFO is not empty, so a read strobe consumes the word already visible.
//
// Ports:
//   clk_in        : clock, all state changes on the rising edge
//   areset_b      : synchronous reset, active HIGH despite the name (1 = reset)
//   trans_write   : push data_in on this edge
//   trans_read    : pop the head word on this edge
//   data_in       : write data
//   data_out      : head-of-FIFO word, 0 while empty
//   full_ind      : occupancy == OSTD_NUM
//   empty_ind     : occupancy == 0
//   overflow_ind  : one-cycle pulse after a write dropped because FIFO was full
//   underflow_ind : one-cycle pulse after a read attempted while empty
//   threshold_ind : occupancy >= THRESHOLD_VALUE
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned OSTD_NUM        = 16,
    parameter int unsigned THRESHOLD_VALUE = OSTD_NUM / 2
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  trans_write,
    input  logic                  trans_read,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full_ind,
    output logic                  empty_ind,
    output logic                  overflow_ind,
    output logic                  underflow_ind,
    output logic                  threshold_ind
);

    localparam int unsigned AW = $clog2(OSTD_NUM);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable by a plain subtraction.
    localparam logic [AW:0] FULL_COUNT   = (AW + 1)'(OSTD_NUM);
    localparam logic [AW:0] THRESH_COUNT = (AW + 1)'(THRESHOLD_VALUE);
    localparam logic [AW:0] PTR_ONE      = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [OSTD_NUM];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] occupancy;

    logic is_full;
    logic is_empty;
    logic rd_accept;
    logic wr_accept;

    // -------------------------------------------------------------------------
    // Occupancy and status
    // -------------------------------------------------------------------------
    always_comb begin
        occupancy = wr_ptr - rd_ptr;
        is_full   = (occupancy == FULL_COUNT);
        is_empty  = (occupancy == '0);
    end

    // A read is only honoured when something is stored. When full, an
    // accepted read frees the slot the same-cycle write lands in.
    always_comb begin
        rd_accept = trans_read && !is_empty;
        wr_accept = trans_write && (!is_full || rd_accept);
    end

    assign full_ind      = is_full;
    assign empty_ind     = is_empty;
    assign threshold_ind = (occupancy >= THRESH_COUNT);

    // Show-ahead output: zero when empty so no stale or uninitialised
    // storage ever reaches the port.
    always_comb begin
        data_out = '0;
        if (!is_empty) begin
            data_out = mem[rd_ptr[AW-1:0]];
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and error pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (areset_b) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow_ind  <= 1'b0;
            underflow_ind <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            overflow_ind  <= trans_write && is_full && !rd_accept;
            underflow_ind <= trans_read && is_empty;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array, deliberately not reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!areset_b && wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_mem.sv
module tb_fifo_mem;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int THR   = 8;

    logic          clk_in = 1'b0;
    logic          areset_b;
    logic          trans_write;
    logic          trans_read;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full_ind;
    logic          empty_ind;
    logic          overflow_ind;
    logic          underflow_ind;
    logic          threshold_ind;

    fifo_mem #(
        .DATA_WIDTH      (DW),
        .OSTD_NUM        (DEPTH),
        .THRESHOLD_VALUE (THR)
    ) dut (
        .clk_in        (clk_in),
        .areset_b      (areset_b),
        .trans_write   (trans_write),
        .trans_read    (trans_read),
        .data_in       (data_in),
        .data_out      (data_out),
        .full_ind      (full_ind),
        .empty_ind     (empty_ind),
        .overflow_ind  (overflow_ind),
        .underflow_ind (underflow_ind),
        .threshold_ind (threshold_ind)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO content as a queue plus the pending error pulses.
    logic [DW-1:0] q[$];
    logic          exp_ovf = 1'b0;
    logic          exp_udf = 1'b0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          udf;
        logic          thr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] hd;
        hd = (q.size() != 0) ? q[0] : '0;
        chk({tag, "_dout"},  32'(data_out),      32'(hd));
        chk({tag, "_empty"}, 32'(empty_ind),     32'(q.size() == 0));
        chk({tag, "_full"},  32'(full_ind),      32'(q.size() == DEPTH));
        chk({tag, "_thr"},   32'(threshold_ind), 32'(q.size() >= THR));
        chk({tag, "_ovf"},   32'(overflow_ind),  32'(exp_ovf));
        chk({tag, "_udf"},   32'(underflow_ind), 32'(exp_udf));
    endtask

    // One clock edge with the given strobes; model advanced from pre-edge state.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input string tag);
        logic was_empty;
        logic was_full;
        logic rd_ok;
        logic wr_ok;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        rd_ok     = rd && !was_empty;
        wr_ok     = wr && (!was_full || rd_ok);
        exp_udf   = rd && was_empty;
        exp_ovf   = wr && was_full && !rd_ok;
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(din);
        trans_write = wr;
        trans_read  = rd;
        data_in     = din;
        @(posedge clk_in);
        #1;
        trans_write = 1'b0;
        trans_read  = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        areset_b    = 1'b1;
        trans_write = 1'b0;
        trans_read  = 1'b0;
        @(posedge clk_in);
        #1;
        areset_b = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        check_model(tag);
        chk({tag, "_const_empty"}, 32'(empty_ind), 32'(1));
        chk({tag, "_const_dout"},  32'(data_out),  32'(0));
    endtask

    initial begin
        areset_b    = 1'b1;
        trans_write = 1'b0;
        trans_read  = 1'b0;
        data_in     = '0;

        // {wr, rd, din, dout, empty, full, ovf, udf, thr}, starting from empty
        tbl[0] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0002, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        do_reset("reset0");

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, "tbl");
            chk("tbl_dout",  32'(data_out),      32'(tbl[i].dout));
            chk("tbl_empty", 32'(empty_ind),     32'(tbl[i].empty));
            chk("tbl_full",  32'(full_ind),      32'(tbl[i].full));
            chk("tbl_ovf",   32'(overflow_ind),  32'(tbl[i].ovf));
            chk("tbl_udf",   32'(underflow_ind), 32'(tbl[i].udf));
            chk("tbl_thr",   32'(threshold_ind), 32'(tbl[i].thr));
        end

        // Basic write/read of 15 words
        do_reset("reset_basic");
        for (int i = 1; i <= 15; i++) step(1'b1, 1'b0, 16'(i), "basic_wr");
        for (int i = 1; i <= 15; i++) begin
            chk("basic_order", 32'(data_out), 32'(i));
            step(1'b0, 1'b1, '0, "basic_rd");
        end
        chk("basic_empty_end", 32'(empty_ind), 32'(1));

        // Fill to full, overflow, drain
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h00A0 + 16'(i), "fill_wr");
        chk("fill_full", 32'(full_ind), 32'(1));
        chk("fill_thr",  32'(threshold_ind), 32'(1));
        step(1'b1, 1'b0, 16'hFFFF, "ovf_wr");
        chk("ovf_pulse", 32'(overflow_ind), 32'(1));
        step(1'b0, 1'b0, '0, "ovf_idle");
        chk("ovf_clear", 32'(overflow_ind), 32'(0));
        for (int i = 0; i < 16; i++) begin
            chk("fill_drain", 32'(data_out), 32'(16'h00A0 + 16'(i)));
            step(1'b0, 1'b1, '0, "fill_rd");
        end

        // Threshold boundary
        do_reset("reset_thr");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'(i), "thr_wr");
        chk("thr_at7", 32'(threshold_ind), 32'(0));
        step(1'b1, 1'b0, 16'h0007, "thr_wr8");
        chk("thr_at8", 32'(threshold_ind), 32'(1));
        step(1'b0, 1'b1, '0, "thr_rd");
        chk("thr_back7", 32'(threshold_ind), 32'(0));

        // Underflow and simultaneous read/write while empty
        do_reset("reset_udf");
        step(1'b0, 1'b1, '0, "udf_rd");
        chk("udf_pulse", 32'(underflow_ind), 32'(1));
        chk("udf_dout",  32'(data_out), 32'(0));
        step(1'b1, 1'b1, 16'h1234, "udf_rw");
        chk("udf_rw_pulse", 32'(underflow_ind), 32'(1));
        chk("udf_rw_dout",  32'(data_out), 32'(16'h1234));
        chk("udf_rw_empty", 32'(empty_ind), 32'(0));

        // Full with simultaneous read and write
        do_reset("reset_frw");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), "frw_fill");
        step(1'b1, 1'b1, 16'h5555, "frw_rw");
        chk("frw_full", 32'(full_ind), 32'(1));
        chk("frw_ovf",  32'(overflow_ind), 32'(0));
        chk("frw_head", 32'(data_out), 32'(16'h0101));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("frw_last", 32'(data_out), 32'(16'h5555));
            step(1'b0, 1'b1, '0, "frw_drain");
        end

        // Interleaved traffic across pointer wrap
        do_reset("reset_wrap");
        for (int i = 0; i < 40; i++) begin
            if (i >= 3) chk("wrap_order", 32'(data_out), 32'(i - 2));
            step(1'b1, (i >= 3), 16'(i + 1), "wrap");
        end

        // Reset with 5 words stored
        do_reset("reset_pre5");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0E00 + 16'(i), "mid_wr");
        do_reset("reset_mid");
        step(1'b1, 1'b0, 16'h0BEE, "post_reset_wr");
        chk("post_reset_dout", 32'(data_out), 32'(16'h0BEE));

        // Randomized traffic against the queue model
        for (int i = 0; i < 1500; i++) begin
            int ph;
            int pw;
            int pr;
            ph = (i / 100) % 3;
            pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            pr = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                     16'($urandom), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
